// File: rtl/ktane_io_pkg.sv
// ============================================================================
// Module   : ktane_io_pkg
// Brief    : Button channel map and default pin polarity for the KTANE IO path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ktane_io_pkg;

    localparam int KTANE_NUM_BUTTONS = 8;

    localparam int BTN_BIG      = 0;
    localparam int BTN_MORSE_L  = 1;
    localparam int BTN_MORSE_R  = 2;
    localparam int BTN_MORSE_TX = 3;
    localparam int BTN_KP_TL    = 4;
    localparam int BTN_KP_TR    = 5;
    localparam int BTN_KP_LL    = 6;
    localparam int BTN_KP_LR    = 7;

    // Every module pin on the board is wired active-low.
    localparam logic [KTANE_NUM_BUTTONS-1:0] KTANE_DEFAULT_INVERT_MASK = 8'hFF;

endpackage : ktane_io_pkg

`default_nettype wire

// File: rtl/ktane_input_conditioner_if.sv
// ============================================================================
// Module   : ktane_input_conditioner_if
// Brief    : Raw button pins in, clean levels / edge events / sticky flags out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ktane_input_conditioner_if
    import ktane_io_pkg::*;
#(
    parameter int NUM_IN = KTANE_NUM_BUTTONS
);
    logic [NUM_IN-1:0] raw_in;
    logic [NUM_IN-1:0] clean;
    logic [NUM_IN-1:0] press;
    logic [NUM_IN-1:0] release_pulse;
    logic [NUM_IN-1:0] clear_flags;
    logic [NUM_IN-1:0] press_flags;

    modport master (
        output raw_in,
        output clear_flags,
        input  clean,
        input  press,
        input  release_pulse,
        input  press_flags
    );

    modport slave (
        input  raw_in,
        input  clear_flags,
        output clean,
        output press,
        output release_pulse,
        output press_flags
    );

endinterface : ktane_input_conditioner_if

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module   : debounce_channel
// Brief    : One button: 2-flop sync, polarity fix, debounce, edge pulses and
//            optional sticky press flag (KTANE_EVENT_LATCH_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
    import ktane_io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic INVERT          = 1'b1
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  i_raw,
    input  wire  i_clear_flag,
    output logic o_clean,
    output logic o_press,
    output logic o_release,
    output logic o_press_flag
);
    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_clean;
    logic               r_press;
    logic               r_release;
    logic               w_sync;

    assign w_sync = r_sync2 ^ INVERT;

    // Sync flops reset to INVERT so the normalised level starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= INVERT;
            r_sync2   <= INVERT;
            r_cnt     <= '0;
            r_clean   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_sync == r_clean) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_clean   <= w_sync;
                r_cnt     <= '0;
                r_press   <= w_sync;
                r_release <= ~w_sync;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef KTANE_EVENT_LATCH_EN
    logic r_flag;

    // A press in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flag <= 1'b0;
        end else if (r_press) begin
            r_flag <= 1'b1;
        end else if (i_clear_flag) begin
            r_flag <= 1'b0;
        end
    end

    assign o_press_flag = r_flag;
`else
    // Flag feature absent: output tied low, clear input has no effect.
    assign o_press_flag = i_clear_flag & 1'b0;
`endif

    assign o_clean   = r_clean;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule : debounce_channel

`default_nettype wire

// File: rtl/ktane_input_conditioner.sv
// ============================================================================
// Module   : ktane_input_conditioner
// Brief    : Conditions all raw module buttons into clean levels and events.
//            Optional sticky press flags: define KTANE_EVENT_LATCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ktane_input_conditioner
    import ktane_io_pkg::*;
#(
    parameter int                NUM_IN          = KTANE_NUM_BUTTONS,
    parameter int                DEBOUNCE_CYCLES = 500000,
    parameter logic [NUM_IN-1:0] INVERT_MASK     = KTANE_DEFAULT_INVERT_MASK
) (
    input wire                        clk,
    input wire                        reset,
    ktane_input_conditioner_if.slave  bus
);

    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .INVERT          (INVERT_MASK[i])
            ) u_chan (
                .clk          (clk),
                .reset        (reset),
                .i_raw        (bus.raw_in[i]),
                .i_clear_flag (bus.clear_flags[i]),
                .o_clean      (bus.clean[i]),
                .o_press      (bus.press[i]),
                .o_release    (bus.release_pulse[i]),
                .o_press_flag (bus.press_flags[i])
            );
        end
    endgenerate

endmodule : ktane_input_conditioner

`default_nettype wire

// File: doc/ktane_input_conditioner.md
Name: ktane_input_conditioner

Overview:
- Upstream stage of the memory-mapped IO decoder; every raw module push-button passes through this block before reaching the button peripheral.
- Each raw input is synchronised, debounced and polarity-normalised, so the decoder always sees clean active-high levels.
- The block also emits one-cycle press and release pulses, which firmware-visible logic uses as event sources.

Parameters:
- NUM_IN, 8, number of button channels. Bit order: 0 button, 1 morse_left, 2 morse_right, 3 morse_tx, 4 keypad_TL, 5 keypad_TR, 6 keypad_LL, 7 keypad_LR.
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a new level (10 ms at 50 MHz). Legal minimum is 2.
- INVERT_MASK, 8'hFF, per-channel XOR applied after synchronisation. 1 means the raw pin is active-low.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- raw_in  input  NUM_IN  unsynchronised button pins
- clean  output  NUM_IN  debounced active-high level, feeds the decoder's button inputs
- press  output  NUM_IN  one-cycle pulse on each accepted 0->1 of clean
- release  output  NUM_IN  one-cycle pulse on each accepted 1->0 of clean
- clear_flags  input  NUM_IN  per-channel sticky-flag clear (see Optional Feature)
- press_flags  output  NUM_IN  sticky press record (see Optional Feature)

Behaviour:
- Reset (async assert, release on a clk edge):
  - Both synchroniser stages hold the value that yields a normalised 0.
  - clean, press, release and press_flags are 0; all counters are 0.
  - Reset asserted mid-debounce discards the count; no pulse is generated.
- Synchroniser: two flops per channel, then XOR with INVERT_MASK, giving sync[i].
- Per channel, the counter cnt has width $clog2(DEBOUNCE_CYCLES).
  - If sync == clean: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: clean <= sync and cnt <= 0. This is the "commit".
  - Else: cnt <= cnt+1.
- Any sample with sync == clean during counting restarts the window. A glitch shorter than DEBOUNCE_CYCLES never reaches clean.
- Latency: a raw change held steady appears on clean exactly 2 + DEBOUNCE_CYCLES clock edges after the first edge that samples it.
- press/release:
  - Both are registered and high in the same cycle that clean first shows the new value.
  - Each is exactly one cycle wide; press and release are never both high on one channel.
- The counter saturates by construction: it is always zeroed on commit and never wraps.
- Channels are fully independent. Simultaneous commits on several channels yield simultaneous pulses.
- No combinational path exists from raw_in to any output.

Optional Feature:
- Macro: KTANE_EVENT_LATCH_EN.
- Defined:
  - press_flags[i] sets on press[i] and clears on clear_flags[i].
  - If set and clear occur in the same cycle, set wins.
  - The flag is visible the cycle after the press pulse.
- Undefined:
  - press_flags is driven constant 0 and clear_flags is ignored.
  - The port list is identical in both builds.

Decomposition:
- Package ktane_io_pkg:
  - KTANE_NUM_BUTTONS = 8.
  - Channel index localparams: BTN_BIG, BTN_MORSE_L, BTN_MORSE_R, BTN_MORSE_TX, BTN_KP_TL, BTN_KP_TR, BTN_KP_LL, BTN_KP_LR.
  - Default INVERT_MASK constant.
- Sub-module debounce_channel holds the synchroniser, normalisation, counter, clean, press, release and optional flag for one channel.
- Top level instantiates debounce_channel NUM_IN times in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, INVERT_MASK=8'h00 unless stated):
- Reset with raw_in=8'hFF held -> clean=0 during reset. clean=8'hFF exactly 6 edges after reset release, with press=8'hFF for that one cycle.
- Channel 1: raw 0->1 held -> clean[1] rises on edge 6, press[1]=1 for 1 cycle. Raw 1->0 held -> release[1] 1 cycle, 6 edges later.
- Bounce: raw[3] toggles 1,0,1,0 for 3 cycles each, then holds 1 -> clean[3] rises exactly 6 edges after the final 0->1; only one press pulse.
- INVERT_MASK=8'h01, raw[0]=0 held -> clean[0]=1 after 6 edges; raw[0] held 1 -> clean[0] stays 0.
- Reset asserted when cnt=3 on channel 5 -> clean[5] stays 0, no press. After release, the full 6-edge latency applies again.
- KTANE_EVENT_LATCH_EN: press[2] then clear_flags[2] -> flag set, then cleared. clear_flags[2] coincident with press[2] -> flag=1. Without the macro, press_flags=0 throughout.
